// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main control FSM:
// opcodes, ALUop encodings, state encoding and the strobe bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001100;
    localparam logic [5:0] OP_SUBI = 6'b001101;
    localparam logic [5:0] OP_SW   = 6'b010000;
    localparam logic [5:0] OP_LW   = 6'b010001;

    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] alu_op;
        logic       alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ill_op;
    } ctrl_t;

    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_R) || (op == OP_ADDI) || (op == OP_SUBI)
            || (op == OP_SW) || (op == OP_LW);
    endfunction

    function automatic logic op_is_mem(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational strobe decode from the registered state, the
// IR opcode and the memory-ready handshake.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_state)
            S_IF: begin
                o_ctrl.mem_req  = 1'b1;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ir_write = i_mem_ready;
                o_ctrl.pc_write = i_mem_ready;
            end
            S_ID: begin
                o_ctrl.ill_op = !op_known(i_opcode);
            end
            S_EX: begin
                o_ctrl.alu_src_b = (i_opcode != OP_R);
                unique case (1'b1)
                    (i_opcode == OP_R):    o_ctrl.alu_op = ALUOP_R;
                    (i_opcode == OP_SUBI): o_ctrl.alu_op = ALUOP_SUB;
                    default:               o_ctrl.alu_op = ALUOP_ADD;
                endcase
            end
            S_MEM: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
                o_ctrl.mem_read  = (i_opcode == OP_LW);
                o_ctrl.mem_write = (i_opcode == OP_SW);
            end
            S_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = (i_opcode == OP_R);
                o_ctrl.mem_to_reg = (i_opcode == OP_LW);
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle main control: state register, next-state logic
// and retired-instruction counter around the strobe decoder.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       ALUop,
    output logic             alu_src_b,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             ill_op,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;
    ctrl_t            w_ctrl;
    ctrl_t            w_out;

    ctrl_out_decode u_dec (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        unique case (r_state)
            S_IF: begin
                if (mem_ready) w_next = S_ID;
            end
            S_ID: begin
                w_next = op_known(opcode) ? S_EX : S_IF;
            end
            S_EX: begin
                w_next = op_is_mem(opcode) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_IF;
                        w_retire = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_next   = S_IF;
                w_retire = 1'b1;
            end
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IF;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    // reset kills any in-flight access, including a pending memory wait
    assign w_out = rst ? ctrl_t'('0) : w_ctrl;

    assign mem_req    = w_out.mem_req;
    assign mem_read   = w_out.mem_read;
    assign mem_write  = w_out.mem_write;
    assign i_or_d     = w_out.i_or_d;
    assign ir_write   = w_out.ir_write;
    assign pc_write   = w_out.pc_write;
    assign ALUop      = w_out.alu_op;
    assign alu_src_b  = w_out.alu_src_b;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign reg_write  = w_out.reg_write;
    assign ill_op     = w_out.ill_op;
    assign retired    = r_retired;
    assign state      = r_state;

endmodule
